// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, instruction field positions and
// the one-word/two-word classification used by fetch and control.
package cpu_pkg;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_LDM = 5'd13;
    localparam logic [4:0] OP_JZ  = 5'd16;
    localparam logic [4:0] OP_JN  = 5'd17;
    localparam logic [4:0] OP_JC  = 5'd18;
    localparam logic [4:0] OP_JMP = 5'd19;
    localparam logic [4:0] OP_SHL = 5'd30;
    localparam logic [4:0] OP_SHR = 5'd31;

    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 11;
    localparam int RDST_MSB  = 10;
    localparam int RDST_LSB  = 8;
    localparam int RSRC1_MSB = 7;
    localparam int RSRC1_LSB = 5;
    localparam int RSRC2_MSB = 4;
    localparam int RSRC2_LSB = 2;

    typedef enum logic {
        S_WORD1,
        S_IMM
    } fetch_state_e;

    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] rdst;
        logic [2:0] rsrc1;
        logic [2:0] rsrc2;
    } instr_fields_t;

    // Opcodes whose immediate lives in the following instruction word.
    function automatic logic is_two_word(input logic [4:0] opcode);
        return (opcode == OP_LDM) || (opcode == OP_SHL) || (opcode == OP_SHR);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new packet, insert a bubble, or hold.
// A bubble always presents NOP_OPCODE so decode sees no side effects.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter int         ADDR_W     = 16,
    parameter logic [4:0] NOP_OPCODE = OP_NOP
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                bubble,
    input  instr_fields_t       fields_in,
    input  logic [15:0]         imm_in,
    input  logic [ADDR_W-1:0]   pc_next_in,
    output logic                valid,
    output instr_fields_t       fields_out,
    output logic [15:0]         imm,
    output logic [ADDR_W-1:0]   pc_next
);

    localparam instr_fields_t BUBBLE_FIELDS = '{opcode: NOP_OPCODE, rdst: 3'd0, rsrc1: 3'd0, rsrc2: 3'd0};

    logic                valid_q,   valid_d;
    instr_fields_t       fields_q,  fields_d;
    logic [15:0]         imm_q,     imm_d;
    logic [ADDR_W-1:0]   pc_next_q, pc_next_d;

    always_comb begin
        valid_d   = valid_q;
        fields_d  = fields_q;
        imm_d     = imm_q;
        pc_next_d = pc_next_q;
        if (bubble) begin
            valid_d   = 1'b0;
            fields_d  = BUBBLE_FIELDS;
            imm_d     = '0;
            pc_next_d = '0;
        end else if (load) begin
            valid_d   = 1'b1;
            fields_d  = fields_in;
            imm_d     = imm_in;
            pc_next_d = pc_next_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            fields_q  <= BUBBLE_FIELDS;
            imm_q     <= '0;
            pc_next_q <= '0;
        end else begin
            valid_q   <= valid_d;
            fields_q  <= fields_d;
            imm_q     <= imm_d;
            pc_next_q <= pc_next_d;
        end
    end

    assign valid      = valid_q;
    assign fields_out = fields_q;
    assign imm        = imm_q;
    assign pc_next    = pc_next_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, two-word instruction assembly and
// stall/flush/redirect handling in front of the IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [4:0]        NOP_OPCODE = OP_NOP
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [15:0]         imem_data,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                id_valid,
    output logic [4:0]          id_opcode,
    output logic [2:0]          id_rdst,
    output logic [2:0]          id_rsrc1,
    output logic [2:0]          id_rsrc2,
    output logic [15:0]         id_imm,
    output logic [ADDR_W-1:0]   id_pc_next
);

    logic [ADDR_W-1:0] pc_q,    pc_d;
    fetch_state_e      state_q, state_d;
    logic [15:0]       held_q,  held_d;

    logic [ADDR_W-1:0] pc_inc;
    logic [15:0]       src_word;
    logic [15:0]       imm_word;
    logic              load;
    logic              bubble;
    instr_fields_t     fields;
    instr_fields_t     fields_out;
    logic [1:0]        unused_low_bits;

    assign pc_inc = pc_q + ADDR_W'(1);

    always_comb begin
        pc_d     = pc_q;
        state_d  = state_q;
        held_d   = held_q;
        src_word = imem_data;
        imm_word = '0;
        load     = 1'b0;
        bubble   = 1'b0;
        if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = S_WORD1;
            held_d  = '0;
            bubble  = 1'b1;
        end else if (!stall) begin
            pc_d = pc_inc;
            if (state_q == S_IMM) begin
                src_word = held_q;
                imm_word = imem_data;
                load     = 1'b1;
                state_d  = S_WORD1;
            end else if (is_two_word(imem_data[OPC_MSB:OPC_LSB])) begin
                held_d  = imem_data;
                state_d = S_IMM;
                bubble  = 1'b1;
            end else begin
                load = 1'b1;
            end
        end
    end

    always_comb begin
        fields.opcode = src_word[OPC_MSB:OPC_LSB];
        fields.rdst   = src_word[RDST_MSB:RDST_LSB];
        fields.rsrc1  = src_word[RSRC1_MSB:RSRC1_LSB];
        fields.rsrc2  = src_word[RSRC2_MSB:RSRC2_LSB];
    end

    // The two low instruction bits carry no field in this ISA.
    assign unused_low_bits = src_word[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= S_WORD1;
            held_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            held_q  <= held_d;
        end
    end

    if_id_reg #(
        .ADDR_W     (ADDR_W),
        .NOP_OPCODE (NOP_OPCODE)
    ) u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .bubble     (bubble),
        .fields_in  (fields),
        .imm_in     (imm_word),
        .pc_next_in (pc_inc),
        .valid      (id_valid),
        .fields_out (fields_out),
        .imm        (id_imm),
        .pc_next    (id_pc_next)
    );

    assign imem_addr = pc_q;
    assign id_opcode = fields_out.opcode;
    assign id_rdst   = fields_out.rdst;
    assign id_rsrc1  = fields_out.rsrc1;
    assign id_rsrc2  = fields_out.rsrc2;

endmodule
